mac_job_sched: RTL and testbench
================================

Name: mac_job_sched

Overview:
Job scheduler in front of the MAC-array tile controller. Two host requesters each submit matrix jobs, given as an MNT dimension word plus a tag, through their own queue. The block validates each job and round-robin arbitrates between the queues. It issues a 1-cycle START with a held MNT to the tile controller, waits for that controller's whole-matrix done, and then returns a tagged completion to the owning requester.

Parameters:
QDEPTH, 2, entries per requester queue (power of 2, >=2)
TAGW, 4, job tag width
WDOG_CYC, 1023, watchdog limit in cycles (used only with MAC_WDOG_EN)

Ports:
CLK  in  1  clock
RST  in  1  reset
REQ0_VALID  in  1  requester 0 job valid
REQ0_READY  out  1  requester 0 queue not full
REQ0_MNT  in  12  {M,N,T}, each 4 bits
REQ0_TAG  in  TAGW  requester 0 tag
REQ1_VALID / REQ1_READY / REQ1_MNT / REQ1_TAG  same meanings, requester 1
START  out  1  1-cycle job start to tile controller
MNT  out  12  dimensions of the issued job, held until next issue
CALC_DONE  in  1  1-cycle pulse from controller: whole matrix finished
ABORT  out  1  1-cycle controller abort (watchdog only)
CMP_VALID  out  1  1-cycle completion pulse
CMP_REQ  out  1  requester id of the completed job
CMP_TAG  out  TAGW  tag of the completed job
CMP_ERR  out  2  00 ok, 01 illegal dims, 10 timeout
BUSY  out  1  state != IDLE or any queue non-empty

Behaviour:
- One clock (CLK). Reset (RST) is synchronous and active-high.
- Reset: queues empty, state IDLE, rr_last=1 (so requester 0 wins first), all outputs 0 (MNT=0, REQx_READY=0 during reset, 1 the cycle after).
- Reset mid-job drops every queued and in-flight job with no completion; a later stray CALC_DONE is ignored.
- Push: entry written at the edge where VALID&READY is high.
- READY = !full. It is evaluated from registered queue state, so a same-cycle pop does not free a slot for a push.
- FSM states: IDLE, ISSUE, WAIT, CMPL.
- IDLE, either head present: pick the winner.
  - Both heads present: winner = !rr_last. One head present: that requester.
  - On the edge: pop the head, latch tag/req, update rr_last.
  - Dims legal (M,N,T each in 1..8): latch MNT, go to ISSUE.
  - Dims illegal: go to CMPL with err=01; no START is issued.
- ISSUE: START=1 for exactly this cycle, then go to WAIT. CALC_DONE is ignored in ISSUE.
- WAIT: on CALC_DONE, go to CMPL with err=00.
- CMPL: CMP_VALID=1 with CMP_REQ/CMP_TAG/CMP_ERR for one cycle, then go to IDLE.
  - CMP fields hold their last value; they are valid only while CMP_VALID=1.
- CALC_DONE outside WAIT is ignored.
- Latency: handshake in cycle k → START in cycle k+2 (queue empty, IDLE). CALC_DONE in cycle j → CMP_VALID in cycle j+1.
- Back-to-back: CMPL → IDLE → ISSUE, so a queued job restarts 2 cycles after the completion pulse.
- Starvation-free: with both queues loaded, grants strictly alternate.

Optional Feature:
MAC_WDOG_EN
- Defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches WDOG_CYC without CALC_DONE: ABORT=1 for one cycle (the cycle leaving WAIT), then CMPL with err=10.
  - CALC_DONE in the same cycle as expiry wins: err=00, no ABORT.
- Undefined: no counter, WAIT persists indefinitely, ABORT tied to 0, err=10 never produced.

Decomposition:
- Package mac_sched_pkg holds:
  - the state enum
  - the CMP_ERR code constants
  - the MNT field slice positions
  - the function dims_legal(mnt)
  - the max-dimension constant 8
- Sub-module mac_job_fifo: synchronous FIFO, width 12+TAGW, depth QDEPTH, with full/empty flags. It is instantiated once per requester.

Test Plan:
- Single job: REQ0 MNT=0x888, TAG=3 pushed at cycle 5 → START at cycle 7 with MNT=0x888; CALC_DONE at cycle 30 → CMP_VALID at cycle 31, REQ=0, TAG=3, ERR=00.
- Fairness: REQ0 and REQ1 each push 2 jobs in the same cycles → START order is req0, req1, req0, req1; CMP_REQ sequence 0,1,0,1.
- Backpressure: while in WAIT, REQ1 pushes 3 jobs with QDEPTH=2 → READY drops after 2 pushes; the 3rd is held by the host and accepted after the first pop.
- Illegal dims: REQ1 MNT=0x058 (M=0), TAG=9 → no START; CMP_VALID 1 cycle after grant with ERR=01, TAG=9.
- Reset in WAIT: RST=1 for 1 cycle, then CALC_DONE → no CMP_VALID, BUSY=0, READY=1.
- MAC_WDOG_EN, WDOG_CYC=15: job issued, no CALC_DONE → ABORT and CMP ERR=10 after 15 WAIT cycles. A repeat run with CALC_DONE on the expiry cycle → ERR=00 and no ABORT.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared types, codes and dimension checks for mac_job_sched
package mac_sched_pkg;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_ISSUE = 2'd1;
  localparam sched_state_t ST_WAIT  = 2'd2;
  localparam sched_state_t ST_CMPL  = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIMS    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int MNT_W = 12;
  localparam int M_HI  = 11;
  localparam int M_LO  = 8;
  localparam int N_HI  = 7;
  localparam int N_LO  = 4;
  localparam int T_HI  = 3;
  localparam int T_LO  = 0;

  localparam int MAX_DIM = 8;

  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(MAX_DIM));
  endfunction

  function automatic logic dims_legal(input logic [MNT_W-1:0] mnt);
    return dim_ok(mnt[M_HI:M_LO]) && dim_ok(mnt[N_HI:N_LO]) && dim_ok(mnt[T_HI:T_LO]);
  endfunction

endpackage

// File: rtl/mac_job_fifo.sv
// rtl/mac_job_fifo.sv - per-requester job queue, synchronous FIFO with full/empty flags
module mac_job_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_job_sched.sv
// rtl/mac_job_sched.sv - two-requester MAC job scheduler; MAC_WDOG_EN adds the WAIT watchdog
module mac_job_sched
  import mac_sched_pkg::*;
#(
  parameter int QDEPTH   = 2,
  parameter int TAGW     = 4,
  parameter int WDOG_CYC = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [11:0]      REQ0_MNT,
  input  logic [TAGW-1:0]  REQ0_TAG,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [11:0]      REQ1_MNT,
  input  logic [TAGW-1:0]  REQ1_TAG,
  output logic             START,
  output logic [11:0]      MNT,
  input  logic             CALC_DONE,
  output logic             ABORT,
  output logic             CMP_VALID,
  output logic             CMP_REQ,
  output logic [TAGW-1:0]  CMP_TAG,
  output logic [1:0]       CMP_ERR,
  output logic             BUSY
);

  localparam int EW = MNT_W + TAGW;

  logic [EW-1:0]    q0_rdata, q1_rdata, head;
  logic             q0_full, q0_empty, q1_full, q1_empty;
  logic             q0_pop, q1_pop, grant1, abort;
  sched_state_t     state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [MNT_W-1:0] mnt_q, mnt_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic             req_q, req_d;
  logic [1:0]       err_q, err_d;
  logic             wdog_hit;

  assign REQ0_READY = !RST && !q0_full;
  assign REQ1_READY = !RST && !q1_full;

  mac_job_fifo #(.DEPTH(QDEPTH), .W(EW)) u_q0 (
    .clk(CLK), .rst(RST), .push(REQ0_VALID && REQ0_READY), .wdata({REQ0_MNT, REQ0_TAG}),
    .pop(q0_pop), .rdata(q0_rdata), .full(q0_full), .empty(q0_empty)
  );

  mac_job_fifo #(.DEPTH(QDEPTH), .W(EW)) u_q1 (
    .clk(CLK), .rst(RST), .push(REQ1_VALID && REQ1_READY), .wdata({REQ1_MNT, REQ1_TAG}),
    .pop(q1_pop), .rdata(q1_rdata), .full(q1_full), .empty(q1_empty)
  );

`ifdef MAC_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);

  logic [CW-1:0] wdog_q, wdog_d;

  // Counter reads 0 in the first WAIT cycle, so the limit is hit in WAIT cycle WDOG_CYC.
  assign wdog_hit = (state_q == ST_WAIT) && (wdog_q == CW'(WDOG_CYC - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_ISSUE)     wdog_d = '0;
    else if (state_q == ST_WAIT) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC != 0);
  assign wdog_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    mnt_d     = mnt_q;
    tag_d     = tag_q;
    req_d     = req_q;
    err_d     = err_q;
    q0_pop    = 1'b0;
    q1_pop    = 1'b0;
    abort     = 1'b0;
    grant1    = 1'b0;
    head      = q0_rdata;
    case (state_q)
      ST_IDLE: begin
        if (!q0_empty || !q1_empty) begin
          grant1    = q0_empty ? 1'b1 : (q1_empty ? 1'b0 : !rr_last_q);
          head      = grant1 ? q1_rdata : q0_rdata;
          q0_pop    = !grant1;
          q1_pop    = grant1;
          rr_last_d = grant1;
          req_d     = grant1;
          tag_d     = head[TAGW-1:0];
          if (dims_legal(head[EW-1 -: MNT_W])) begin
            mnt_d   = head[EW-1 -: MNT_W];
            state_d = ST_ISSUE;
          end else begin
            err_d   = ERR_DIMS;
            state_d = ST_CMPL;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion arriving on the expiry cycle takes precedence over the abort.
        if (CALC_DONE) begin
          err_d   = ERR_OK;
          state_d = ST_CMPL;
        end else if (wdog_hit) begin
          abort   = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = ST_CMPL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      mnt_q     <= '0;
      tag_q     <= '0;
      req_q     <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      mnt_q     <= mnt_d;
      tag_q     <= tag_d;
      req_q     <= req_d;
      err_q     <= err_d;
    end
  end

  assign START     = (state_q == ST_ISSUE);
  assign CMP_VALID = (state_q == ST_CMPL);
  assign MNT       = mnt_q;
  assign CMP_REQ   = req_q;
  assign CMP_TAG   = tag_q;
  assign CMP_ERR   = err_q;
  assign ABORT     = abort;
  assign BUSY      = (state_q != ST_IDLE) || !q0_empty || !q1_empty;

endmodule

// File: tb/tb_mac_job_sched.sv
// tb/tb_mac_job_sched.sv - scoreboard bench for mac_job_sched (watchdog steps under MAC_WDOG_EN)
module tb_mac_job_sched;

  logic        CLK, RST;
  logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [11:0] REQ0_MNT, REQ1_MNT, MNT;
  logic [3:0]  REQ0_TAG, REQ1_TAG, CMP_TAG;
  logic        START, CALC_DONE, ABORT, CMP_VALID, CMP_REQ, BUSY;
  logic [1:0]  CMP_ERR;

  mac_job_sched #(.QDEPTH(2), .TAGW(4), .WDOG_CYC(15)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_MNT(REQ0_MNT), .REQ0_TAG(REQ0_TAG),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_MNT(REQ1_MNT), .REQ1_TAG(REQ1_TAG),
    .START(START), .MNT(MNT), .CALC_DONE(CALC_DONE), .ABORT(ABORT),
    .CMP_VALID(CMP_VALID), .CMP_REQ(CMP_REQ), .CMP_TAG(CMP_TAG), .CMP_ERR(CMP_ERR), .BUSY(BUSY)
  );

  typedef struct { logic [11:0] mnt; int cyc; } st_exp_t;
  typedef struct { logic req; logic [3:0] tag; } job_t;
  typedef struct { logic req; logic [3:0] tag; logic [1:0] err; int cyc; } cmp_exp_t;

  st_exp_t  exp_s[$];
  job_t     inflight[$];
  cmp_exp_t exp_c[$];
  int       cyc = 0;
  int       total = 0;
  int       bad = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor pops the scoreboard whenever the DUT produces a START or completion.
  always @(negedge CLK) begin : mon
    st_exp_t  s;
    cmp_exp_t c;
    if (START === 1'b1) begin
      if (exp_s.size() == 0) chk("start_unexpected", 32'(START), 32'd0);
      else begin
        s = exp_s.pop_front();
        chk("start_mnt", 32'(MNT), 32'(s.mnt));
        chk("start_cycle", cyc, s.cyc);
      end
    end
    if (CMP_VALID === 1'b1) begin
      if (exp_c.size() == 0) chk("cmp_unexpected", 32'(CMP_VALID), 32'd0);
      else begin
        c = exp_c.pop_front();
        chk("cmp_req", 32'(CMP_REQ), 32'(c.req));
        chk("cmp_tag", 32'(CMP_TAG), 32'(c.tag));
        chk("cmp_err", 32'(CMP_ERR), 32'(c.err));
        chk("cmp_cycle", cyc, c.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic drive(input bit r, input bit v, input logic [11:0] m, input logic [3:0] t);
    if (r) begin REQ1_VALID = v; REQ1_MNT = m; REQ1_TAG = t; end
    else   begin REQ0_VALID = v; REQ0_MNT = m; REQ0_TAG = t; end
  endtask

  task automatic push_job(input bit r, input logic [11:0] m, input logic [3:0] t, output int k);
    int n = 0;
    drive(r, 1'b1, m, t);
    #1;
    while (!(r ? REQ1_READY : REQ0_READY) && n < 40) begin tick(); n++; end
    chk("push_bound", 32'(n < 40), 32'd1);
    k = cyc;
    tick();
    drive(r, 1'b0, 12'h0, 4'h0);
  endtask

  task automatic push2(input logic [11:0] m0, input logic [3:0] t0,
                       input logic [11:0] m1, input logic [3:0] t1, output int k);
    drive(1'b0, 1'b1, m0, t0);
    drive(1'b1, 1'b1, m1, t1);
    #1;
    chk("push2_ready0", 32'(REQ0_READY), 32'd1);
    chk("push2_ready1", 32'(REQ1_READY), 32'd1);
    k = cyc;
    tick();
    drive(1'b0, 1'b0, 12'h0, 4'h0);
    drive(1'b1, 1'b0, 12'h0, 4'h0);
  endtask

  task automatic expect_start(input logic [11:0] m, input bit r, input logic [3:0] t, input int c);
    exp_s.push_back('{mnt: m, cyc: c});
    inflight.push_back('{req: r, tag: t});
  endtask

  task automatic finish_job(output int j);
    job_t jb;
    CALC_DONE = 1'b1;
    j = cyc;
    jb = inflight.pop_front();
    exp_c.push_back('{req: jb.req, tag: jb.tag, err: 2'b00, cyc: j + 1});
    #1;
    chk("abort_on_done", 32'(ABORT), 32'd0);
    tick();
    CALC_DONE = 1'b0;
  endtask

  initial begin
    int k, j, acc, n;
    RST = 1'b1; CALC_DONE = 1'b0;
    drive(1'b0, 1'b0, 12'h0, 4'h0);
    drive(1'b1, 1'b0, 12'h0, 4'h0);
    tick();
    chk("rst_ready0", 32'(REQ0_READY), 32'd0);
    chk("rst_ready1", 32'(REQ1_READY), 32'd0);
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(REQ0_READY), 32'd1);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    chk("post_rst_start", 32'(START), 32'd0);
    chk("post_rst_cmp", 32'(CMP_VALID), 32'd0);
    chk("post_rst_mnt", 32'(MNT), 32'd0);
    chk("post_rst_abort", 32'(ABORT), 32'd0);

    // Fairness: both requesters load two jobs in the same cycles.
    push2(12'h111, 4'h1, 12'h222, 4'h2, k);
    expect_start(12'h111, 1'b0, 4'h1, k + 2);
    push2(12'h333, 4'h4, 12'h444, 4'h5, n);
    tick_to(k + 6);
    finish_job(j); expect_start(12'h222, 1'b1, 4'h2, j + 3);
    tick_to(j + 8);
    finish_job(j); expect_start(12'h333, 1'b0, 4'h4, j + 3);
    tick_to(j + 8);
    finish_job(j); expect_start(12'h444, 1'b1, 4'h5, j + 3);
    tick_to(j + 8);
    finish_job(j);
    tick_to(j + 4);

    // Single job with the largest legal dimensions.
    push_job(1'b0, 12'h888, 4'h3, k);
    expect_start(12'h888, 1'b0, 4'h3, k + 2);
    tick_to(k + 25);
    chk("wait_busy", 32'(BUSY), 32'd1);
    finish_job(j);
    tick_to(j + 4);

    // Backpressure: REQ1 fills its queue while a REQ0 job sits in WAIT.
    push_job(1'b0, 12'h121, 4'h6, k);
    expect_start(12'h121, 1'b0, 4'h6, k + 2);
    tick_to(k + 4);
    push_job(1'b1, 12'h212, 4'h1, n);
    push_job(1'b1, 12'h213, 4'h2, n);
    drive(1'b1, 1'b1, 12'h214, 4'h3);
    #1;
    chk("bp_ready_low", 32'(REQ1_READY), 32'd0);
    finish_job(j);
    expect_start(12'h212, 1'b1, 4'h1, j + 3);
    n = 0;
    while (!REQ1_READY && n < 20) begin tick(); n++; end
    acc = cyc;
    chk("bp_accept_cycle", acc, j + 3);
    tick();
    drive(1'b1, 1'b0, 12'h0, 4'h0);
    tick_to(j + 8);
    finish_job(j); expect_start(12'h213, 1'b1, 4'h2, j + 3);
    tick_to(j + 8);
    finish_job(j); expect_start(12'h214, 1'b1, 4'h3, j + 3);
    tick_to(j + 8);
    finish_job(j);
    tick_to(j + 4);

    // Illegal dimensions: zero M, then T above the maximum.
    push_job(1'b1, 12'h058, 4'h9, k);
    exp_c.push_back('{req: 1'b1, tag: 4'h9, err: 2'b01, cyc: k + 2});
    tick_to(k + 4);
    push_job(1'b0, 12'h819, 4'ha, k);
    exp_c.push_back('{req: 1'b0, tag: 4'ha, err: 2'b01, cyc: k + 2});
    tick_to(k + 4);
    chk("illegal_mnt_held", 32'(MNT), 32'h214);
    chk("illegal_idle_busy", 32'(BUSY), 32'd0);

    // Reset while a job is in WAIT and another is queued.
    push_job(1'b0, 12'h234, 4'h7, k);
    expect_start(12'h234, 1'b0, 4'h7, k + 2);
    push_job(1'b1, 12'h345, 4'h8, n);
    tick_to(k + 5);
    RST = 1'b1;
    #1;
    chk("rst_wait_ready", 32'(REQ0_READY), 32'd0);
    tick();
    RST = 1'b0;
    inflight.delete();
    #1;
    chk("rst_wait_busy", 32'(BUSY), 32'd0);
    chk("rst_wait_ready0", 32'(REQ0_READY), 32'd1);
    chk("rst_wait_ready1", 32'(REQ1_READY), 32'd1);
    CALC_DONE = 1'b1;
    tick();
    CALC_DONE = 1'b0;
    repeat (4) tick();
    chk("stray_done_busy", 32'(BUSY), 32'd0);

    // After reset requester 0 wins the first contested grant again.
    push2(12'h456, 4'hb, 12'h567, 4'hc, k);
    expect_start(12'h456, 1'b0, 4'hb, k + 2);
    tick_to(k + 5);
    finish_job(j); expect_start(12'h567, 1'b1, 4'hc, j + 3);
    tick_to(j + 6);
    finish_job(j);
    tick_to(j + 4);

`ifdef MAC_WDOG_EN
    push_job(1'b0, 12'h111, 4'hd, k);
    expect_start(12'h111, 1'b0, 4'hd, k + 2);
    tick_to(k + 2 + 14);
    chk("wdog_abort_early", 32'(ABORT), 32'd0);
    tick();
    chk("wdog_abort", 32'(ABORT), 32'd1);
    void'(inflight.pop_front());
    exp_c.push_back('{req: 1'b0, tag: 4'hd, err: 2'b10, cyc: k + 2 + 16});
    tick();
    chk("wdog_abort_pulse", 32'(ABORT), 32'd0);
    tick_to(k + 22);
    push_job(1'b1, 12'h222, 4'he, k);
    expect_start(12'h222, 1'b1, 4'he, k + 2);
    tick_to(k + 2 + 15);
    finish_job(j);
    tick_to(j + 4);
`endif

    n = 0;
    while ((exp_s.size() != 0 || exp_c.size() != 0) && n < 10) begin tick(); n++; end
    chk("drain_start", 32'(exp_s.size()), 32'd0);
    chk("drain_cmp", 32'(exp_c.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
